apb_bridge_v2: RTL and testbench

Parametrised APB3 slave bridge that converts APB3 transfers into the internal single-cycle peripheral strobe interface (p_address/p_data/p_wr/p_rd/p_data_back).
- Next generation of the fixed 6-bit/16-bit bridge.
- Adds configurable address/data width and a programmable read wait count.
- Adds an optional peripheral read-acknowledge handshake with timeout.
- Adds real PSLVERR generation for out-of-range addresses and read timeouts.
- Sits between the APB interconnect and the CDC/register block of the FIR core.

---
 rtl/apb_bridge_v2_pkg.sv | 20 ++
 rtl/apb_bridge_v2_if.sv | 18 +
 rtl/apb_bridge_v2_wait_counter.sv | 25 ++
 rtl/apb_bridge_v2.sv | 145 ++++++++++++++
 tb/tb_apb_bridge_v2.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_bridge_v2_pkg.sv
// Shared types, constants and helpers for the APB3 peripheral bridge.
package apb_bridge_pkg;

  localparam int APB_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Counter width needed to hold max(RD_WAIT, TIMEOUT) - 1; never narrower than 1 bit.
  function automatic int cnt_width(input int rd_wait, input int timeout);
    int m;
    m = (rd_wait > timeout) ? rd_wait : timeout;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/apb_bridge_v2_if.sv
// APB3 bus bundle between the interconnect (master) and the bridge (slave).
interface apb_bridge_v2_if;
  import apb_bridge_pkg::*;

  logic [APB_W-1:0] PADDR;
  logic             PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [APB_W-1:0] PWDATA;
  logic             PREADY;
  logic [APB_W-1:0] PRDATA;
  logic             PSLVERR;

  modport master (output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                  input  PREADY, PRDATA, PSLVERR);
  modport slave  (input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
                  output PREADY, PRDATA, PSLVERR);
endinterface

// File: rtl/apb_bridge_v2_wait_counter.sv
// Clear/enable up-counter with terminal-count compare; used for both the
// fixed read wait and the ack timeout.
module apb_wait_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Count while enabled; clear has priority so every read starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/apb_bridge_v2.sv
// APB3 slave -> single-cycle peripheral strobe bridge with configurable widths,
// fixed or acknowledged read latency, and PSLVERR on bad address / ack timeout.
module apb_bridge_v2
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int RD_WAIT  = 6,
  parameter int ACK_MODE = 0,
  parameter int TIMEOUT  = 64
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_bridge_v2_if.slave    apb,
  output logic [ADDR_W-1:0] p_address,
  output logic [DATA_W-1:0] p_data,
  output logic              p_wr,
  output logic              p_rd,
  input  logic [DATA_W-1:0] p_data_back,
  input  logic              p_rd_ack
);

  localparam int              CNT_W  = cnt_width(RD_WAIT, TIMEOUT);
  // Terminal count is the last waiting cycle: the edge that sees it completes the read.
  localparam int              TERM_I = (ACK_MODE != 0) ? TIMEOUT - 1 : RD_WAIT - 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(TERM_I);

  state_e              r_state, w_state_nxt;
  logic                r_pready, r_pslverr, r_p_wr, r_p_rd;
  logic [APB_W-1:0]    r_prdata;
  logic [ADDR_W-1:0]   r_p_address;
  logic [DATA_W-1:0]   r_p_data;
  logic                w_pready, w_pslverr, w_p_wr, w_p_rd;
  logic [APB_W-1:0]    w_prdata;
  logic [ADDR_W-1:0]   w_p_address;
  logic [DATA_W-1:0]   w_p_data;
  logic                w_setup, w_addr_err, w_ack, w_tc, w_cnt_clr, w_cnt_en;
  logic [APB_W-1:0]    w_unused_wdata;

  assign w_setup        = apb.PSEL & ~apb.PENABLE;
  assign w_addr_err     = (apb.PADDR >> ADDR_W) != '0;
  assign w_ack          = (ACK_MODE != 0) && p_rd_ack;
  assign w_cnt_clr      = (r_state != READ);
  assign w_cnt_en       = (r_state == READ);
  assign w_unused_wdata = apb.PWDATA;

  apb_wait_counter #(.W(CNT_W)) u_wait (
    .clk    (PCLK),
    .rst    (PRESET),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .i_term (TERM),
    .o_tc   (w_tc)
  );

  // State register plus the registered bus/strobe outputs; reset aborts any transfer.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= IDLE;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
      r_p_wr      <= 1'b0;
      r_p_rd      <= 1'b0;
      r_prdata    <= '0;
      r_p_address <= '0;
      r_p_data    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pready    <= w_pready;
      r_pslverr   <= w_pslverr;
      r_p_wr      <= w_p_wr;
      r_p_rd      <= w_p_rd;
      r_prdata    <= w_prdata;
      r_p_address <= w_p_address;
      r_p_data    <= w_p_data;
    end
  end

  // Next state: setups only accepted in IDLE; PSEL loss in READ abandons the read.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:        if (w_setup) w_state_nxt = w_addr_err ? RESP : (apb.PWRITE ? WRITE : READ);
      WRITE, RESP: w_state_nxt = IDLE;
      READ: begin
        if (!apb.PSEL)          w_state_nxt = IDLE;
        else if (w_ack || w_tc) w_state_nxt = RESP;
      end
      default:     w_state_nxt = IDLE;
    endcase
  end

  // Output next-values: one-cycle pulses default low, data/address hold.
  always_comb begin
    w_pready    = 1'b0;
    w_pslverr   = 1'b0;
    w_p_wr      = 1'b0;
    w_p_rd      = 1'b0;
    w_prdata    = r_prdata;
    w_p_address = r_p_address;
    w_p_data    = r_p_data;
    case (r_state)
      IDLE: if (w_setup) begin
        if (w_addr_err) begin
          w_pready  = 1'b1;
          w_pslverr = 1'b1;
          if (!apb.PWRITE) w_prdata = '0;
        end else if (apb.PWRITE) begin
          w_p_address = apb.PADDR[ADDR_W-1:0];
          w_p_data    = apb.PWDATA[DATA_W-1:0];
          w_p_wr      = 1'b1;
          w_pready    = 1'b1;
        end else begin
          w_p_address = apb.PADDR[ADDR_W-1:0];
          w_p_rd      = 1'b1;
        end
      end
      READ: if (apb.PSEL) begin
        // Ack is checked first so an ack landing on the timeout edge still succeeds.
        if (w_ack) begin
          w_pready = 1'b1;
          w_prdata = APB_W'(p_data_back);
        end else if (w_tc) begin
          w_pready = 1'b1;
          if (ACK_MODE != 0) begin
            w_pslverr = 1'b1;
            w_prdata  = '0;
          end else begin
            w_prdata  = APB_W'(p_data_back);
          end
        end
      end
      default: ;
    endcase
  end

  assign apb.PREADY  = r_pready;
  assign apb.PSLVERR = r_pslverr;
  assign apb.PRDATA  = r_prdata;
  assign p_address   = r_p_address;
  assign p_data      = r_p_data;
  assign p_wr        = r_p_wr;
  assign p_rd        = r_p_rd;

endmodule

// File: tb/tb_apb_bridge_v2.sv
// Scoreboard bench: two bridges (fixed-wait and ack-mode) share one APB master;
// the master pushes expected responses/strobes, a monitor pops and compares.
module tb_apb_bridge_v2;
  import apb_bridge_pkg::*;

  typedef struct { logic [31:0] prdata; logic err; int waits; } resp_t;
  typedef struct { logic wr; logic [5:0] addr; logic [15:0] data; } strb_t;

  localparam int FIX_WAIT = 6;
  localparam int TMO      = 8;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, sel = 1'b0, ack = 1'b0;
  logic [15:0] dback = '0;
  logic [5:0]  addr0, addr1;
  logic [15:0] data0, data1;
  logic        wr0, rd0, wr1, rd1;

  int n_cmp = 0, n_err = 0, wcnt = 0;
  resp_t rq[$];
  strb_t sq[$];
  logic [31:0] last_prd [2];

  always #5 PCLK = ~PCLK;

  apb_bridge_v2_if bus0();
  apb_bridge_v2_if bus1();
  assign bus0.PADDR = paddr;  assign bus1.PADDR = paddr;
  assign bus0.PWDATA = pwdata; assign bus1.PWDATA = pwdata;
  assign bus0.PWRITE = pwrite; assign bus1.PWRITE = pwrite;
  assign bus0.PENABLE = penable; assign bus1.PENABLE = penable;
  assign bus0.PSEL = psel & ~sel;
  assign bus1.PSEL = psel & sel;

  apb_bridge_v2 #(.ADDR_W(6), .DATA_W(16), .RD_WAIT(FIX_WAIT), .ACK_MODE(0), .TIMEOUT(64)) u_fix (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus0), .p_address(addr0), .p_data(data0),
    .p_wr(wr0), .p_rd(rd0), .p_data_back(dback), .p_rd_ack(ack));

  apb_bridge_v2 #(.ADDR_W(6), .DATA_W(16), .RD_WAIT(2), .ACK_MODE(1), .TIMEOUT(TMO)) u_ack (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus1), .p_address(addr1), .p_data(data1),
    .p_wr(wr1), .p_rd(rd1), .p_data_back(dback), .p_rd_ack(ack));

  logic        m_pready, m_pslverr, m_wr, m_rd;
  logic [31:0] m_prdata;
  logic [5:0]  m_addr;
  logic [15:0] m_data;
  assign m_pready  = sel ? bus1.PREADY  : bus0.PREADY;
  assign m_pslverr = sel ? bus1.PSLVERR : bus0.PSLVERR;
  assign m_prdata  = sel ? bus1.PRDATA  : bus0.PRDATA;
  assign m_wr      = sel ? wr1 : wr0;
  assign m_rd      = sel ? rd1 : rd0;
  assign m_addr    = sel ? addr1 : addr0;
  assign m_data    = sel ? data1 : data0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: strobes against the strobe queue, completions against the response queue.
  always @(negedge PCLK) begin
    if (PRESET) begin
      wcnt = 0;
    end else begin
      chk("idle_dut_strobe", sel ? {31'd0, wr0 | rd0} : {31'd0, wr1 | rd1}, 0);
      if (m_wr || m_rd) begin
        chk("strobe_expected", sq.size(), (sq.size() == 0) ? 1 : sq.size());
        if (sq.size() != 0) begin
          strb_t s;
          s = sq.pop_front();
          chk("strobe_kind_wr", {31'd0, m_wr}, {31'd0, s.wr});
          chk("strobe_kind_rd", {31'd0, m_rd}, {31'd0, ~s.wr});
          chk("p_address", {26'd0, m_addr}, {26'd0, s.addr});
          if (s.wr) chk("p_data", {16'd0, m_data}, {16'd0, s.data});
        end
      end
      if (psel && penable) begin
        if (!m_pready) wcnt++;
        else begin
          chk("resp_expected", rq.size(), (rq.size() == 0) ? 1 : rq.size());
          if (rq.size() != 0) begin
            resp_t r;
            r = rq.pop_front();
            chk("PRDATA", m_prdata, r.prdata);
            chk("PSLVERR", {31'd0, m_pslverr}, {31'd0, r.err});
            chk("wait_cycles", wcnt, r.waits);
          end
          wcnt = 0;
        end
      end else wcnt = 0;
    end
  end

  // One APB transfer; d = cycle on which p_rd_ack is sampled (values > TMO never ack).
  task automatic xfer(input logic s, input logic [31:0] a, input logic w,
                      input logic [31:0] wd, input int d, input logic [15:0] db);
    resp_t r;
    strb_t st;
    bit done;
    int k;
    if ((a >> 6) != 0) begin
      r.prdata = w ? last_prd[s] : 32'd0; r.err = 1'b1; r.waits = 0;
    end else if (w) begin
      r.prdata = last_prd[s]; r.err = 1'b0; r.waits = 0;
      st.wr = 1'b1; st.addr = a[5:0]; st.data = wd[15:0]; sq.push_back(st);
    end else begin
      st.wr = 1'b0; st.addr = a[5:0]; st.data = '0; sq.push_back(st);
      if (!s)                      begin r.prdata = {16'd0, db}; r.err = 1'b0; r.waits = FIX_WAIT; end
      else if (d >= 1 && d <= TMO) begin r.prdata = {16'd0, db}; r.err = 1'b0; r.waits = d; end
      else                         begin r.prdata = 32'd0;       r.err = 1'b1; r.waits = TMO; end
    end
    last_prd[s] = r.prdata;
    rq.push_back(r);
    sel = s; psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = wd; dback = db; ack = 1'b0;
    @(posedge PCLK); #1;
    penable = 1'b1;
    k = 0;
    ack = !w && (d == 1);
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge PCLK);
      if (m_pready) begin done = 1; break; end
      @(posedge PCLK); #1;
      k++;
      ack = !w && (d == k + 1);
    end
    if (!done) chk("xfer_completes", 0, 1);
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0; ack = 1'($urandom_range(0, 1));
  endtask

  initial begin
    last_prd[0] = '0; last_prd[1] = '0;
    #1 PRESET = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    chk("rst_PREADY0", {31'd0, bus0.PREADY}, 0);
    chk("rst_PRDATA0", bus0.PRDATA, 0);
    chk("rst_PSLVERR1", {31'd0, bus1.PSLVERR}, 0);
    chk("rst_strobes", {28'd0, wr0, rd0, wr1, rd1}, 0);
    @(posedge PCLK); #1 PRESET = 1'b0;
    repeat (2) @(posedge PCLK); #1;

    // Directed cases
    xfer(0, 32'h05, 1, 32'h0000BEEF, 1, 16'h0);
    xfer(0, 32'h09, 0, 32'h0, 1, 16'h1234);
    xfer(0, 32'h40, 0, 32'h0, 1, 16'h5555);
    xfer(1, 32'h11, 0, 32'h0, 3, 16'hA5A5);
    xfer(1, 32'h12, 0, 32'h0, 99, 16'h7777);
    xfer(1, 32'h13, 0, 32'h0, TMO, 16'h0F0F);
    xfer(0, 32'h21, 1, 32'h1234CAFE, 1, 16'h0);
    xfer(0, 32'h22, 0, 32'h0, 1, 16'h4321);
    xfer(1, 32'h80000000, 1, 32'h1, 1, 16'h0);
    repeat (3) @(posedge PCLK); #1;

    // Randomised mix, mostly back-to-back
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 5) == 0) a = $urandom | (32'd1 << $urandom_range(6, 31));
      xfer(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), $urandom,
           $urandom_range(1, TMO + 2), 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin @(posedge PCLK); #1; end
    end

    // PSEL withdrawn mid-read: bridge returns to IDLE silently
    begin
      strb_t st;
      st.wr = 1'b0; st.addr = 6'h0A; st.data = '0; sq.push_back(st);
      sel = 0; psel = 1; penable = 0; pwrite = 0; paddr = 32'h0A; ack = 0;
      @(posedge PCLK); #1 penable = 1;
      repeat (2) @(posedge PCLK); #1;
      psel = 0; penable = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge PCLK);
        chk("drop_no_PREADY", {31'd0, bus0.PREADY}, 0);
      end
      @(posedge PCLK); #1;
      xfer(0, 32'h0B, 0, 32'h0, 1, 16'h2468);
    end

    // Reset in the middle of a read
    begin
      strb_t st;
      st.wr = 1'b0; st.addr = 6'h03; st.data = '0; sq.push_back(st);
      sel = 0; psel = 1; penable = 0; pwrite = 0; paddr = 32'h03; ack = 0;
      @(posedge PCLK); #1 penable = 1;
      repeat (3) @(posedge PCLK);
      #3 PRESET = 1'b1;
      #1;
      chk("midrst_PREADY", {31'd0, bus0.PREADY}, 0);
      chk("midrst_PRDATA", bus0.PRDATA, 0);
      chk("midrst_PSLVERR", {31'd0, bus0.PSLVERR}, 0);
      chk("midrst_p_address", {26'd0, addr0}, 0);
      chk("midrst_p_data", {16'd0, data0}, 0);
      chk("midrst_strobes", {30'd0, wr0, rd0}, 0);
      psel = 0; penable = 0;
      last_prd[0] = '0; last_prd[1] = '0;
      @(posedge PCLK); #1 PRESET = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge PCLK);
        chk("postrst_quiet", {30'd0, bus0.PREADY, rd0}, 0);
      end
      @(posedge PCLK); #1;
      xfer(0, 32'h0C, 0, 32'h0, 1, 16'h1357);
    end

    repeat (4) @(posedge PCLK);
    chk("resp_queue_drained", rq.size(), 0);
    chk("strobe_queue_drained", sq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
